// File: rtl/nibble_serial_alu_if.sv
// Host-side handshake and operand bus for the nibble-serial ALU sequencer.
interface nibble_serial_alu_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic [1:0]             op;
    logic                   cin;
    logic [4*NIBBLES-1:0]   a;
    logic [4*NIBBLES-1:0]   b;
    logic                   ready;
    logic                   done;
    logic [4*NIBBLES-1:0]   result;
    logic                   cout;
    logic                   ovf;

    modport master (
        output start, op, cin, a, b,
        input  ready, done, result, cout, ovf
    );

    modport slave (
        input  start, op, cin, a, b,
        output ready, done, result, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_alu_ctrl.sv
// Steps one 4-bit arithmetic unit across a 4*NIBBLES-bit word, LSB nibble first,
// chaining the carry through a register.
//
// state | meaning
// IDLE  | ready=1, waiting for start; latches operands on accept
// RUN   | one nibble per cycle through the 4-bit unit
// DONE  | one-cycle done pulse; result/cout/ovf valid
module nibble_serial_alu_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    nibble_serial_alu_if.slave   bus
);
    localparam int WIDTH = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W+1:0]   base;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [1:0]         op_reg;
    logic               cin_reg;
    logic               ready_r;
    logic               done_r;
    logic [WIDTH-1:0]   result_r;
    logic               cout_r;
    logic               ovf_r;

    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [3:0]         eff_b;
    logic [3:0]         d;
    logic               c_in;
    logic               c_out;

    assign base  = {idx, 2'b00};
    assign a_nib = a_reg[base +: 4];
    assign b_nib = b_reg[base +: 4];
    assign c_in  = (idx == '0) ? cin_reg : carry;

    // 4-bit arithmetic unit: S1,S0 pick the B operand, then a plain add with carry
    always_comb begin
        eff_b = 4'h0;
        case (op_reg)
            2'b00:   eff_b = b_nib;
            2'b01:   eff_b = ~b_nib;
            2'b10:   eff_b = 4'h0;
            default: eff_b = 4'hF;
        endcase
        {c_out, d} = {1'b0, a_nib} + {1'b0, eff_b} + {4'b0000, c_in};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= 2'b00;
            cin_reg  <= 1'b0;
            ready_r  <= 1'b1;
            done_r   <= 1'b0;
            result_r <= '0;
            cout_r   <= 1'b0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_reg   <= bus.a;
                        b_reg   <= bus.b;
                        op_reg  <= bus.op;
                        cin_reg <= bus.cin;
                        idx     <= '0;
                        ready_r <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    result_r[base +: 4] <= d;
                    carry               <= c_out;
                    idx                 <= idx + 1'b1;
                    if (idx == LAST_IDX) begin
                        cout_r <= c_out;
                        ovf_r  <= (a_nib[3] == eff_b[3]) && (d[3] != a_nib[3]);
                        idx    <= '0;
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    ready_r <= 1'b1;
                    done_r  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = ready_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;
    assign bus.cout   = cout_r;
    assign bus.ovf    = ovf_r;
endmodule
